gauss_share_arbiter: RTL and testbench
======================================

Name: gauss_share_arbiter

Overview:
Shares one gauss7 filter instance between two EventScheduler7_end window producers, source 0 and source 1. Each source has a one-window holding buffer and its own request handshake. Window requests from the filter are granted round-robin among the full buffers. A tag FIFO records the source of every window forwarded to the filter, so each filtered event is routed back to the correct sink in order.

Parameters:
DATA_WIDTH, 4, bit width of one raw event/window pixel value
DATA_WIDTH_2, DATA_WIDTH+12, bit width of a filtered event value
TAG_FIFO_DEPTH, 8, maximum windows in flight inside the filter; power of 2, at least 2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
src_window_value_0/1  in  49*DATA_WIDTH  7x7 window from scheduler 0/1
src_window_addr_0/1  in  16  window centre address
src_window_valid_0/1  in  1  one-cycle window strobe
src_window_req_0/1  out  1  one-cycle request pulse to scheduler 0/1
flt_window_value  out  49*DATA_WIDTH  window to gauss7
flt_window_addr  out  16  address to gauss7
flt_window_valid  out  1  one-cycle window strobe to gauss7
flt_window_req  in  1  one-cycle request pulse from gauss7
flt_event_value  in  DATA_WIDTH_2  filtered value from gauss7
flt_event_addr  in  16  filtered address
flt_event_valid  in  1  filtered event strobe
flt_ready_for_new_event  out  1  backpressure to gauss7
out_event_value  out  DATA_WIDTH_2  broadcast to both sinks
out_event_addr  out  16  broadcast to both sinks
out_event_valid_0/1  out  1  event strobe for sink 0/1
sink_ready_0/1  in  1  sink 0/1 can accept an event

Behaviour:
- Reset (rst_n=0 at a clock edge) applies to all state:
  - All registered outputs go to 0.
  - Buffers are empty; outstanding flags, pending flag and RR pointer are 0; tag FIFO is empty.
  - Reset asserted mid-operation discards buffered windows and in-flight tags. Filter results that arrive afterwards are dropped.
- Per-source request logic (s=0,1):
  - src_window_req_s is registered. It pulses for 1 cycle when buf_s is empty, outstanding_s=0 and rst_n=1.
  - The pulse sets outstanding_s. The first pulses therefore occur in the first cycle after reset release.
  - src_window_valid_s with outstanding_s=1 captures value and addr into buf_s, marks it full and clears outstanding_s.
  - src_window_valid_s with outstanding_s=0 is ignored.
- Pending flag:
  - flt_window_req sets pending.
  - A further flt_window_req while pending is already set is absorbed; only one request is held.
- Grant:
  - Condition: pending=1, at least one buffer full, tag count < TAG_FIFO_DEPTH.
  - When the condition holds, the next cycle drives flt_window_valid=1 with the granted buffer's data. In the same edge: that buffer becomes empty, the source id is pushed into the tag FIFO, and pending is cleared.
  - Request-to-window latency is 1 cycle when a buffer is already full.
  - If the tag FIFO is full, the grant is blocked even when a pop happens in the same cycle.
- Round-robin:
  - When both buffers are full, the source named by rr_ptr wins. When only one is full, that one wins.
  - After any grant to source s, rr_ptr becomes 1-s.
- Refill: the emptied source's req pulse appears on the cycle after the grant, coinciding with flt_window_valid.
- Result routing (combinational):
  - head is the tag at the FIFO head.
  - out_event_valid_s = flt_event_valid & !tag_empty & (head==s).
  - out_event_value and out_event_addr are driven directly from flt_event_value and flt_event_addr.
  - flt_ready_for_new_event = tag_empty ? 1 : sink_ready_head.
  - flt_event_valid with the tag FIFO non-empty pops one tag.
  - flt_event_valid with the tag FIFO empty is dropped with no pop.
  - A push and a pop in the same cycle leave the count unchanged.
- Tag FIFO: circular buffer with log2(TAG_FIFO_DEPTH)-bit pointers that wrap modulo depth, plus an explicit count register.

Optional Feature:
GSA_FIXED_PRIORITY_EN
- Defined: source 0 always wins when both buffers are full. rr_ptr is not implemented.
- Undefined (default): round-robin as above.

Test Plan:
- Reset release, both sources idle: src_window_req_0 and src_window_req_1 each pulse exactly once on the first post-reset cycle, then stay 0 until the sources supply windows.
- Source 0 delivers addr 0x0102, then flt_window_req pulses: flt_window_valid is high 1 cycle later with addr 0x0102, and src_window_req_0 pulses in that same cycle. A later flt_event_valid with value 0x1234 raises out_event_valid_0 only.
- Both buffers full (addrs 0x0A0A and 0x0B0B), 4 filter requests while the sources refill immediately: grant order is 0,1,0,1. With GSA_FIXED_PRIORITY_EN defined, the order is 0,0,0,0.
- Forward 8 windows with no filter results returned: tag count reaches 8, and the 9th flt_window_req produces no flt_window_valid until one flt_event_valid pops a tag; the window then issues the following cycle.
- Tag head = source 1 with sink_ready_1=0 and sink_ready_0=1: flt_ready_for_new_event=0. Raising sink_ready_1 sets it to 1.
- Two windows in flight, assert rst_n=0 for 1 cycle, then inject flt_event_valid: out_event_valid_0 and out_event_valid_1 both stay 0, and the tag count stays 0.

Source files
------------

// File: rtl/gauss_share_arbiter.sv
// Shares one gauss7 filter between two window producers; a source-tag FIFO routes filtered events back in order.
// Optional: define GSA_FIXED_PRIORITY_EN to make source 0 win ties instead of round-robin.
module gauss_share_arbiter #(
    parameter int DATA_WIDTH     = 4,
    parameter int DATA_WIDTH_2   = DATA_WIDTH + 12,
    parameter int TAG_FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [49*DATA_WIDTH-1:0] src_window_value_0,
    input  logic [49*DATA_WIDTH-1:0] src_window_value_1,
    input  logic [15:0]              src_window_addr_0,
    input  logic [15:0]              src_window_addr_1,
    input  logic                     src_window_valid_0,
    input  logic                     src_window_valid_1,
    output logic                     src_window_req_0,
    output logic                     src_window_req_1,
    output logic [49*DATA_WIDTH-1:0] flt_window_value,
    output logic [15:0]              flt_window_addr,
    output logic                     flt_window_valid,
    input  logic                     flt_window_req,
    input  logic [DATA_WIDTH_2-1:0]  flt_event_value,
    input  logic [15:0]              flt_event_addr,
    input  logic                     flt_event_valid,
    output logic                     flt_ready_for_new_event,
    output logic [DATA_WIDTH_2-1:0]  out_event_value,
    output logic [15:0]              out_event_addr,
    output logic                     out_event_valid_0,
    output logic                     out_event_valid_1,
    input  logic                     sink_ready_0,
    input  logic                     sink_ready_1
);
    localparam int WIN_W = 49 * DATA_WIDTH;
    localparam int PTR_W = $clog2(TAG_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TAG_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIN_W-1:0]          win_in_s [2];
    logic [15:0]               addr_in_s [2];
    logic [1:0]                valid_in_s;
    logic [WIN_W-1:0]          buf_value_q [2];
    logic [WIN_W-1:0]          buf_value_d [2];
    logic [15:0]               buf_addr_q [2];
    logic [15:0]               buf_addr_d [2];
    logic [1:0]                buf_full_q, buf_full_d;
    logic [1:0]                outstanding_q, outstanding_d;
    logic [1:0]                src_req_q, src_req_d;
    logic                      pending_q, pending_d;
    logic [TAG_FIFO_DEPTH-1:0] tag_mem_q, tag_mem_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          tag_cnt_q, tag_cnt_d;
    logic                      flt_valid_q, flt_valid_d;
    logic [WIN_W-1:0]          flt_value_q, flt_value_d;
    logic [15:0]               flt_addr_q, flt_addr_d;
    logic                      pending_eff_s, grant_s, grant_src_s;
    logic                      tag_empty_s, head_s, pop_s;
    logic [1:0]                grant_hit_s;

    assign win_in_s[0]  = src_window_value_0;
    assign win_in_s[1]  = src_window_value_1;
    assign addr_in_s[0] = src_window_addr_0;
    assign addr_in_s[1] = src_window_addr_1;
    assign valid_in_s   = {src_window_valid_1, src_window_valid_0};

    // A request arriving this cycle can be served immediately, hence the OR with the held flag.
    assign pending_eff_s = pending_q | flt_window_req;
    assign grant_s       = pending_eff_s & (|buf_full_q) & (tag_cnt_q < DEPTH_C);
    assign grant_hit_s   = grant_s ? (grant_src_s ? 2'b10 : 2'b01) : 2'b00;

`ifdef GSA_FIXED_PRIORITY_EN
    assign grant_src_s = ~buf_full_q[0];
`else
    logic rr_ptr_q;
    assign grant_src_s = (&buf_full_q) ? rr_ptr_q : ~buf_full_q[0];

    // Round-robin pointer: the next tie goes to the source not just served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else if (grant_s) begin
            rr_ptr_q <= ~grant_src_s;
        end else begin
            rr_ptr_q <= rr_ptr_q;
        end
    end
`endif

    assign tag_empty_s             = (tag_cnt_q == {CNT_W{1'b0}});
    assign head_s                  = tag_mem_q[rd_ptr_q];
    assign pop_s                   = flt_event_valid & ~tag_empty_s;
    assign out_event_valid_0       = flt_event_valid & ~tag_empty_s & ~head_s;
    assign out_event_valid_1       = flt_event_valid & ~tag_empty_s & head_s;
    assign out_event_value         = flt_event_value;
    assign out_event_addr          = flt_event_addr;
    assign flt_ready_for_new_event = tag_empty_s ? 1'b1 : (head_s ? sink_ready_1 : sink_ready_0);

    assign src_window_req_0 = src_req_q[0];
    assign src_window_req_1 = src_req_q[1];
    assign flt_window_valid = flt_valid_q;
    assign flt_window_value = flt_value_q;
    assign flt_window_addr  = flt_addr_q;

    // Per-source buffer: capture a requested window, or re-request once empty (including the grant cycle).
    always_comb begin
        buf_full_d    = buf_full_q;
        outstanding_d = outstanding_q;
        src_req_d     = 2'b00;
        buf_value_d   = buf_value_q;
        buf_addr_d    = buf_addr_q;
        for (int s = 0; s < 2; s++) begin
            if (valid_in_s[s] && outstanding_q[s]) begin
                buf_value_d[s]   = win_in_s[s];
                buf_addr_d[s]    = addr_in_s[s];
                buf_full_d[s]    = 1'b1;
                outstanding_d[s] = 1'b0;
            end else if (!outstanding_q[s] && (!buf_full_q[s] || grant_hit_s[s])) begin
                src_req_d[s]     = 1'b1;
                outstanding_d[s] = 1'b1;
                buf_full_d[s]    = 1'b0;
            end else begin
                buf_full_d[s]    = buf_full_q[s];
            end
        end
    end

    // Grant to the filter and tag FIFO bookkeeping.
    always_comb begin
        tag_mem_d   = tag_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        flt_valid_d = grant_s;
        flt_value_d = flt_value_q;
        flt_addr_d  = flt_addr_q;
        pending_d   = pending_eff_s & ~grant_s;
        if (grant_s) begin
            flt_value_d          = buf_value_q[grant_src_s];
            flt_addr_d           = buf_addr_q[grant_src_s];
            tag_mem_d[wr_ptr_q]  = grant_src_s;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d             = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({grant_s, pop_s})
            2'b10:   tag_cnt_d = tag_cnt_q + CNT_ONE;
            2'b01:   tag_cnt_d = tag_cnt_q - CNT_ONE;
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_value_q[0] <= {WIN_W{1'b0}};
            buf_value_q[1] <= {WIN_W{1'b0}};
            buf_addr_q[0]  <= 16'h0000;
            buf_addr_q[1]  <= 16'h0000;
            buf_full_q     <= 2'b00;
            outstanding_q  <= 2'b00;
            src_req_q      <= 2'b00;
            pending_q      <= 1'b0;
            tag_mem_q      <= {TAG_FIFO_DEPTH{1'b0}};
            wr_ptr_q       <= {PTR_W{1'b0}};
            rd_ptr_q       <= {PTR_W{1'b0}};
            tag_cnt_q      <= {CNT_W{1'b0}};
            flt_valid_q    <= 1'b0;
            flt_value_q    <= {WIN_W{1'b0}};
            flt_addr_q     <= 16'h0000;
        end else begin
            buf_value_q    <= buf_value_d;
            buf_addr_q     <= buf_addr_d;
            buf_full_q     <= buf_full_d;
            outstanding_q  <= outstanding_d;
            src_req_q      <= src_req_d;
            pending_q      <= pending_d;
            tag_mem_q      <= tag_mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            tag_cnt_q      <= tag_cnt_d;
            flt_valid_q    <= flt_valid_d;
            flt_value_q    <= flt_value_d;
            flt_addr_q     <= flt_addr_d;
        end
    end
endmodule

// File: tb/tb_gauss_share_arbiter.sv
// Randomized plus directed bench for gauss_share_arbiter against a queue-based reference model.
module tb_gauss_share_arbiter;
    localparam int DW    = 4;
    localparam int DW2   = DW + 12;
    localparam int DEPTH = 8;
    localparam int WIN_W = 49 * DW;
`ifdef GSA_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIN_W-1:0] src_window_value_0, src_window_value_1;
    logic [15:0]      src_window_addr_0, src_window_addr_1;
    logic             src_window_valid_0, src_window_valid_1;
    logic             src_window_req_0, src_window_req_1;
    logic [WIN_W-1:0] flt_window_value;
    logic [15:0]      flt_window_addr;
    logic             flt_window_valid;
    logic             flt_window_req;
    logic [DW2-1:0]   flt_event_value;
    logic [15:0]      flt_event_addr;
    logic             flt_event_valid;
    logic             flt_ready_for_new_event;
    logic [DW2-1:0]   out_event_value;
    logic [15:0]      out_event_addr;
    logic             out_event_valid_0, out_event_valid_1;
    logic             sink_ready_0, sink_ready_1;

    always #5 clk = ~clk;

    gauss_share_arbiter #(.DATA_WIDTH(DW), .DATA_WIDTH_2(DW2), .TAG_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_window_value_0(src_window_value_0), .src_window_value_1(src_window_value_1),
        .src_window_addr_0(src_window_addr_0), .src_window_addr_1(src_window_addr_1),
        .src_window_valid_0(src_window_valid_0), .src_window_valid_1(src_window_valid_1),
        .src_window_req_0(src_window_req_0), .src_window_req_1(src_window_req_1),
        .flt_window_value(flt_window_value), .flt_window_addr(flt_window_addr),
        .flt_window_valid(flt_window_valid), .flt_window_req(flt_window_req),
        .flt_event_value(flt_event_value), .flt_event_addr(flt_event_addr),
        .flt_event_valid(flt_event_valid), .flt_ready_for_new_event(flt_ready_for_new_event),
        .out_event_value(out_event_value), .out_event_addr(out_event_addr),
        .out_event_valid_0(out_event_valid_0), .out_event_valid_1(out_event_valid_1),
        .sink_ready_0(sink_ready_0), .sink_ready_1(sink_ready_1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: buffers as flags, in-flight windows as a queue of source ids.
    bit               m_full [2];
    bit               m_outst [2];
    bit               m_req [2];
    logic [WIN_W-1:0] m_val [2];
    logic [15:0]      m_addr [2];
    bit               m_pend, m_rr, m_fv;
    logic [WIN_W-1:0] m_fval;
    logic [15:0]      m_faddr;
    int               m_tags [$];

    task automatic model_step();
        bit pend, g, pop, vld [2];
        int src;
        logic [WIN_W-1:0] vin [2];
        logic [15:0] ain [2];
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                m_full[s] = 0; m_outst[s] = 0; m_req[s] = 0;
            end
            m_pend = 0; m_rr = 0; m_fv = 0; m_fval = '0; m_faddr = '0;
            m_tags.delete();
            return;
        end
        vld[0] = src_window_valid_0; vld[1] = src_window_valid_1;
        vin[0] = src_window_value_0; vin[1] = src_window_value_1;
        ain[0] = src_window_addr_0;  ain[1] = src_window_addr_1;
        pend = m_pend || flt_window_req;
        g = pend && (m_full[0] || m_full[1]) && (m_tags.size() < DEPTH);
        src = 0;
        if (g) begin
            if (m_full[0] && m_full[1]) src = FIXED ? 0 : int'(m_rr);
            else src = m_full[0] ? 0 : 1;
        end
        pop = flt_event_valid && (m_tags.size() > 0);
        if (pop) void'(m_tags.pop_front());
        m_fv = g;
        if (g) begin
            m_fval = m_val[src];
            m_faddr = m_addr[src];
            m_full[src] = 0;
            m_tags.push_back(src);
            m_rr = (src == 0);
            m_pend = 0;
        end else begin
            m_pend = pend;
        end
        for (int s = 0; s < 2; s++) begin
            m_req[s] = 0;
            if (m_outst[s] && vld[s]) begin
                m_val[s] = vin[s]; m_addr[s] = ain[s]; m_full[s] = 1; m_outst[s] = 0;
            end else if (!m_outst[s] && !m_full[s]) begin
                m_req[s] = 1; m_outst[s] = 1;
            end
        end
    endtask

    task automatic check_regs();
        check_val("src_req_0", src_window_req_0, m_req[0]);
        check_val("src_req_1", src_window_req_1, m_req[1]);
        check_val("flt_valid", flt_window_valid, m_fv);
        if (m_fv) begin
            check_val("flt_addr", flt_window_addr, m_faddr);
            check_val("flt_value", flt_window_value, m_fval);
        end
    endtask

    task automatic check_comb();
        bit has, e0, e1, rdy;
        has = m_tags.size() > 0;
        e0 = flt_event_valid && has && (m_tags[0] == 0);
        e1 = flt_event_valid && has && (m_tags[0] == 1);
        rdy = !has ? 1'b1 : ((m_tags[0] == 1) ? sink_ready_1 : sink_ready_0);
        check_val("out_valid_0", out_event_valid_0, e0);
        check_val("out_valid_1", out_event_valid_1, e1);
        check_val("flt_ready", flt_ready_for_new_event, rdy);
        check_val("out_value", out_event_value, flt_event_value);
        check_val("out_addr", out_event_addr, flt_event_addr);
    endtask

    task automatic cycle();
        #1;
        check_comb();
        @(posedge clk);
        model_step();
        #1;
        check_regs();
    endtask

    function automatic logic [WIN_W-1:0] rand_win();
        logic [WIN_W-1:0] w;
        w = '0;
        for (int i = 0; i < WIN_W; i += 32) w = {w[WIN_W-33:0], 32'($urandom)};
        return w;
    endfunction

    task automatic idle();
        rst_n = 1; src_window_valid_0 = 0; src_window_valid_1 = 0;
        flt_window_req = 0; flt_event_valid = 0; sink_ready_0 = 1; sink_ready_1 = 1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    task automatic grant_and_refill(output logic [15:0] seen, input logic [15:0] a0, input logic [15:0] a1);
        flt_window_req = 1;
        cycle();
        flt_window_req = 0;
        seen = flt_window_addr;
        src_window_valid_0 = src_window_req_0; src_window_value_0 = rand_win(); src_window_addr_0 = a0;
        src_window_valid_1 = src_window_req_1; src_window_value_1 = rand_win(); src_window_addr_1 = a1;
        cycle();
        src_window_valid_0 = 0; src_window_valid_1 = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] seen;
        logic [15:0] exp_order [4];
        idle();
        rst_n = 0;
        src_window_value_0 = '0; src_window_value_1 = '0;
        src_window_addr_0 = '0; src_window_addr_1 = '0;
        flt_event_value = '0; flt_event_addr = '0;
        @(posedge clk);
        model_step();
        #1;
        check_regs();
        check_val("rst_flt_addr", flt_window_addr, 16'h0000);
        check_val("rst_flt_valid", flt_window_valid, 1'b0);

        // Reset release: one request pulse per source, then silence.
        rst_n = 1;
        cycle();
        check_val("rel_req_0", src_window_req_0, 1'b1);
        check_val("rel_req_1", src_window_req_1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("idle_req_0", src_window_req_0, 1'b0);
            check_val("idle_req_1", src_window_req_1, 1'b0);
        end

        // Single window from source 0, one-cycle grant latency, result routed to sink 0.
        src_window_valid_0 = 1; src_window_addr_0 = 16'h0102; src_window_value_0 = rand_win();
        cycle();
        src_window_valid_0 = 0;
        flt_window_req = 1;
        cycle();
        flt_window_req = 0;
        check_val("lat_valid", flt_window_valid, 1'b1);
        check_val("lat_addr", flt_window_addr, 16'h0102);
        check_val("lat_refill_req", src_window_req_0, 1'b1);
        cycle();
        flt_event_valid = 1; flt_event_value = 16'h1234; flt_event_addr = 16'h0102;
        #1;
        check_val("route_v0", out_event_valid_0, 1'b1);
        check_val("route_v1", out_event_valid_1, 1'b0);
        cycle();
        flt_event_valid = 0;

        // Both full, four requests with immediate refill.
        do_reset();
        cycle();
        src_window_valid_0 = 1; src_window_addr_0 = 16'h0A0A; src_window_value_0 = rand_win();
        src_window_valid_1 = 1; src_window_addr_1 = 16'h0B0B; src_window_value_1 = rand_win();
        cycle();
        src_window_valid_0 = 0; src_window_valid_1 = 0;
        for (int k = 0; k < 4; k++)
            exp_order[k] = (FIXED || (k % 2 == 0)) ? 16'h0A0A : 16'h0B0B;
        for (int k = 0; k < 4; k++) begin
            grant_and_refill(seen, 16'h0A0A, 16'h0B0B);
            check_val("rr_order", seen, exp_order[k]);
        end
        flt_event_valid = 1;
        for (int k = 0; k < 4; k++) begin
            flt_event_value = DW2'($urandom);
            cycle();
        end
        flt_event_valid = 0;

        // Fill the tag FIFO; the ninth request waits for a pop, then issues one cycle later.
        for (int k = 0; k < 8; k++) begin
            grant_and_refill(seen, 16'h1000 + 16'(k), 16'h2000 + 16'(k));
        end
        flt_window_req = 1;
        cycle();
        flt_window_req = 0;
        check_val("full_block", flt_window_valid, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            check_val("full_hold", flt_window_valid, 1'b0);
        end
        flt_event_valid = 1;
        cycle();
        flt_event_valid = 0;
        check_val("full_pop_same", flt_window_valid, 1'b0);
        cycle();
        check_val("full_after_pop", flt_window_valid, 1'b1);

        // Head tag from source 1 follows sink 1 readiness.
        do_reset();
        cycle();
        src_window_valid_1 = 1; src_window_addr_1 = 16'h0B0B; src_window_value_1 = rand_win();
        cycle();
        src_window_valid_1 = 0;
        flt_window_req = 1;
        cycle();
        flt_window_req = 0;
        sink_ready_0 = 1; sink_ready_1 = 0;
        #1;
        check_val("head1_notready", flt_ready_for_new_event, 1'b0);
        sink_ready_1 = 1;
        #1;
        check_val("head1_ready", flt_ready_for_new_event, 1'b1);
        cycle();

        // Two in flight, reset, then late results are dropped.
        src_window_valid_0 = 1; src_window_addr_0 = 16'h0C0C; src_window_value_0 = rand_win();
        src_window_valid_1 = src_window_req_1; src_window_addr_1 = 16'h0D0D;
        cycle();
        src_window_valid_0 = 0; src_window_valid_1 = 0;
        grant_and_refill(seen, 16'h0C0C, 16'h0D0D);
        do_reset();
        sink_ready_0 = 0; sink_ready_1 = 0;
        flt_event_valid = 1; flt_event_value = DW2'($urandom);
        #1;
        check_val("postrst_v0", out_event_valid_0, 1'b0);
        check_val("postrst_v1", out_event_valid_1, 1'b0);
        check_val("postrst_ready", flt_ready_for_new_event, 1'b1);
        cycle();
        #1;
        check_val("postrst_v0b", out_event_valid_0, 1'b0);
        check_val("postrst_ready_b", flt_ready_for_new_event, 1'b1);
        cycle();
        idle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            src_window_valid_0 = ($urandom_range(0, 2) == 0);
            src_window_value_0 = rand_win(); src_window_addr_0 = 16'($urandom);
            src_window_valid_1 = ($urandom_range(0, 2) == 0);
            src_window_value_1 = rand_win(); src_window_addr_1 = 16'($urandom);
            flt_window_req = ($urandom_range(0, 2) == 0);
            flt_event_valid = ($urandom_range(0, 3) == 0);
            flt_event_value = DW2'($urandom); flt_event_addr = 16'($urandom);
            sink_ready_0 = 1'($urandom); sink_ready_1 = 1'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
